// File: rtl/baud_detect_pkg.sv
// Shared definitions for the autobaud detector: rate list, nominal period and
// window helpers, timeout, idle qualifier length and FSM state encodings.
package baud_detect_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_LOW = 3'd2,
        MEASURE  = 3'd3,
        CLASSIFY = 3'd4
    } state_t;

    localparam int unsigned NUM_RATES = 12;
    localparam int unsigned IDLE_QUAL = 16;
    localparam logic [3:0]  SEL_DEFAULT = 4'd4;

    localparam int unsigned RATES [NUM_RATES] = '{
        300, 1200, 2400, 4800, 9600, 19200,
        38400, 57600, 115200, 230400, 460800, 921600
    };

    // Nominal bit period in clock cycles, rounded to nearest.
    function automatic int unsigned nominal(input int unsigned clk_hz, input int unsigned idx);
        return (clk_hz + RATES[idx] / 2) / RATES[idx];
    endfunction

    function automatic int unsigned win_lo(input int unsigned clk_hz, input int unsigned idx);
        return (nominal(clk_hz, idx) * 3) / 4;
    endfunction

    function automatic int unsigned win_hi(input int unsigned clk_hz, input int unsigned idx);
        return (nominal(clk_hz, idx) * 5) / 4;
    endfunction

    // One past the widest window, so any pulse reaching it can never be classified.
    function automatic int unsigned tmax(input int unsigned clk_hz);
        return win_hi(clk_hz, 0) + 1;
    endfunction

endpackage

// File: rtl/baud_detect_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rxs
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            meta <= rx;
            rxs  <= meta;
        end
    end

endmodule

// File: rtl/baud_detect.sv
// Autobaud detector: measures the width of the first start bit after an arm
// pulse and classifies it against the standard rate table.
module baud_detect
    import baud_detect_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       start,
    output logic [3:0] sel,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam logic [18:0] TMAX = 19'(tmax(CLK_HZ));

    state_t      state;
    state_t      state_nx;
    logic        rxs;
    logic [18:0] cnt;
    logic [4:0]  hicnt;
    logic [3:0]  hit_idx;
    logic [3:0]  hit_num;
    logic        hit_one;

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rxs   (rxs)
    );

    // Windows near 38400/57600 overlap; a pulse landing in both is rejected.
    always_comb begin
        hit_idx = 4'd0;
        hit_num = 4'd0;
        for (int unsigned i = 0; i < NUM_RATES; i++) begin
            if (32'(cnt) >= win_lo(CLK_HZ, i) && 32'(cnt) <= win_hi(CLK_HZ, i)) begin
                hit_num = hit_num + 4'd1;
                hit_idx = 4'(i);
            end
        end
        hit_one = (hit_num == 4'd1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = ARM;
            ARM:      if (rxs && hicnt == 5'(IDLE_QUAL - 1)) state_nx = WAIT_LOW;
            WAIT_LOW: if (!rxs) state_nx = MEASURE;
            MEASURE: begin
                if (rxs)
                    state_nx = CLASSIFY;
                else if (cnt == TMAX)
                    state_nx = IDLE;
            end
            CLASSIFY: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            hicnt <= '0;
            sel   <= SEL_DEFAULT;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        valid <= 1'b0;
                        err   <= 1'b0;
                        hicnt <= '0;
                    end
                end
                ARM: hicnt <= rxs ? hicnt + 5'd1 : 5'd0;
                WAIT_LOW: begin
                    if (!rxs)
                        cnt <= 19'd1;
                end
                MEASURE: begin
                    if (!rxs) begin
                        if (cnt == TMAX) begin
                            err   <= 1'b1;
                            valid <= 1'b0;
                        end else begin
                            cnt <= cnt + 19'd1;
                        end
                    end
                end
                CLASSIFY: begin
                    if (hit_one) begin
                        sel   <= hit_idx;
                        valid <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        valid <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
